// File: rtl/spi_slave_datapath.sv
// SPI slave datapath: tx holding buffer + tx/rx shift registers driven by shift/sample pulses from an SPI FSM.
// Latency: rx word visible on the same edge as its last sample pulse; miso follows the shift register combinationally.
// Backpressure: tx_ready low while the one-entry holding buffer is full; rx has none (overrun is flagged, sticky).
//
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   cs, cpha          - active-low chip select (already synchronous), clock phase bit
//   shift, sample     - one-cycle pulses: advance tx bit / capture mosi
//   mosi, miso        - serial data in / out
//   tx_data/valid/ready - next word to transmit (valid/ready handshake)
//   rx_data/valid/ack - last completed received word, held until acknowledged
//   rx_overrun, tx_underrun - sticky error flags, cleared only by reset
//
// Build option: define SPI_LSB_FIRST_EN for LSB-first operation (default MSB-first).

module spi_slave_datapath #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              cpha,
  input  logic              shift,
  input  logic              sample,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              rx_overrun,
  output logic              tx_underrun
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  // State
  logic              cs_q,          cs_d;
  logic [DATA_W-1:0] tx_sr_q,       tx_sr_d;
  logic [CNT_W-1:0]  tx_cnt_q,      tx_cnt_d;
  logic              skip_q,        skip_d;
  // Only DATA_W-1 partial bits need storing; the last bit comes straight from mosi.
  logic [DATA_W-2:0] rx_sr_q,       rx_sr_d;
  logic [CNT_W-1:0]  rx_cnt_q,      rx_cnt_d;
  logic [DATA_W-1:0] hold_q,        hold_d;
  logic              hold_full_q,   hold_full_d;
  logic [DATA_W-1:0] rx_data_q,     rx_data_d;
  logic              rx_valid_q,    rx_valid_d;
  logic              rx_overrun_q,  rx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;

  // Combinational helpers
  logic              frame_start;
  logic              frame_end;
  logic              shift_en;
  logic              sample_en;
  logic              tx_load;
  logic              tx_wr;
  logic [DATA_W-1:0] tx_load_val;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_word;
  logic              tx_out;

  always_comb begin
    frame_start = cs_q & ~cs;
    frame_end   = ~cs_q & cs;
    // The frame-start cycle is spent loading; pulses there are not acted on.
    shift_en    = shift  & ~cs & ~frame_start;
    sample_en   = sample & ~cs & ~frame_start;
    tx_load     = frame_start | (shift_en & ~skip_q & (tx_cnt_q == CNT_LAST));
    // tx_ready reflects the buffer state before this edge, so a load and a
    // write can share a cycle only when the buffer starts empty.
    tx_wr       = tx_valid & ~hold_full_q;
    tx_load_val = hold_full_q ? hold_q : ALL_ONES;
`ifdef SPI_LSB_FIRST_EN
    tx_shifted  = {1'b0, tx_sr_q[DATA_W-1:1]};
    rx_word     = {mosi, rx_sr_q};
    tx_out      = tx_sr_q[0];
`else
    tx_shifted  = {tx_sr_q[DATA_W-2:0], 1'b0};
    rx_word     = {rx_sr_q, mosi};
    tx_out      = tx_sr_q[DATA_W-1];
`endif
  end

  always_comb begin
    cs_d          = cs;
    tx_sr_d       = tx_sr_q;
    tx_cnt_d      = tx_cnt_q;
    skip_d        = skip_q;
    rx_sr_d       = rx_sr_q;
    rx_cnt_d      = rx_cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q & ~rx_ack;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = tx_underrun_q;

    // Transmit side
    if (tx_load) begin
      tx_sr_d     = tx_load_val;
      tx_cnt_d    = '0;
      hold_full_d = 1'b0;
      if (!hold_full_q) begin
        tx_underrun_d = 1'b1;
      end
    end else if (shift_en) begin
      if (skip_q) begin
        // cpha=1: the first shift edge of a frame only arms normal shifting.
        skip_d = 1'b0;
      end else begin
        tx_sr_d  = tx_shifted;
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    end

    if (frame_start) begin
      skip_d = cpha;
    end

    if (tx_wr) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Receive side
    if (frame_start || frame_end) begin
      // Partial word from an aborted frame is dropped; holding buffer kept.
      rx_sr_d  = '0;
      rx_cnt_d = '0;
      if (frame_end) begin
        tx_cnt_d = '0;
        skip_d   = 1'b0;
      end
    end else if (sample_en) begin
`ifdef SPI_LSB_FIRST_EN
      rx_sr_d = rx_word[DATA_W-1:1];
`else
      rx_sr_d = rx_word[DATA_W-2:0];
`endif
      if (rx_cnt_q == CNT_LAST) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
        rx_cnt_d   = '0;
        // An ack in the completing cycle frees the slot in time.
        if (rx_valid_q && !rx_ack) begin
          rx_overrun_d = 1'b1;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q          <= 1'b1;
      tx_sr_q       <= '0;
      tx_cnt_q      <= '0;
      skip_q        <= 1'b0;
      rx_sr_q       <= '0;
      rx_cnt_q      <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      cs_q          <= cs_d;
      tx_sr_q       <= tx_sr_d;
      tx_cnt_q      <= tx_cnt_d;
      skip_q        <= skip_d;
      rx_sr_q       <= rx_sr_d;
      rx_cnt_q      <= rx_cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign miso        = cs ? 1'b0 : tx_out;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: doc/spi_slave_datapath.md
SPI_SLAVE_DATAPATH -- requirements
Module: spi_slave_datapath

Interface
REQ-001 Parameter: DATA_W, default 8, bits per SPI word; legal range 2..32.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cs  input  1  SPI chip select, active-low, already synchronous to clk.
REQ-005 cpha  input  1  clock-phase bit of the SPI mode (mode[0]).
REQ-006 shift  input  1  one-cycle pulse from the SPI FSM: advance the transmit bit.
REQ-007 sample  input  1  one-cycle pulse from the SPI FSM: capture mosi.
REQ-008 mosi  input  1  serial receive data, synchronous to clk.
REQ-009 miso  output  1  serial transmit data.
REQ-010 tx_data  input  DATA_W  next word to transmit.
REQ-011 tx_valid  input  1  tx_data valid; transfer occurs when tx_valid and tx_ready are both 1 on a clock edge.
REQ-012 tx_ready  output  1  high while the one-entry transmit holding buffer is empty.
REQ-013 rx_data  output  DATA_W  last completed received word.
REQ-014 rx_valid  output  1  high from word completion until rx_ack.
REQ-015 rx_ack  input  1  consumer acknowledge; clears rx_valid on the next edge.
REQ-016 rx_overrun  output  1  sticky flag: word completed while rx_valid was still high.
REQ-017 tx_underrun  output  1  sticky flag: shift register loaded while the holding buffer was empty.

Function
REQ-018 cs is registered as cs_q; a frame start is cs_q=1 and cs=0; a frame end is cs_q=0 and cs=1.
REQ-019 shift and sample SHALL be ignored in any cycle where cs=1.
REQ-020 At frame start, the tx shift register loads from the holding buffer (buffer emptied) and rx_cnt, tx_cnt and skip are cleared; skip is then set to cpha.
REQ-021 miso = tx shift register output bit (MSB) while cs=0; miso = 0 while cs=1.
REQ-022 Shift pulse with skip=1: clear skip only; no bit movement and no tx_cnt change.
REQ-023 Shift pulse with skip=0 and tx_cnt<DATA_W-1: shift the register one position, fill with 0, and increment tx_cnt.
REQ-024 Shift pulse with skip=0 and tx_cnt=DATA_W-1: reload from the holding buffer and set tx_cnt=0.
REQ-025 Any load with an empty holding buffer loads all-ones and sets tx_underrun.
REQ-026 Sample pulse: shift mosi into the rx shift register and increment rx_cnt.
REQ-027 On the DATA_W-th sample, in that same clock edge: rx_data receives the full word, rx_valid=1, rx_cnt=0; latency 0 cycles after the pulse edge.
REQ-028 Word completion with rx_valid=1 and no same-cycle rx_ack: rx_data is overwritten and rx_overrun is set.
REQ-029 Completion and rx_ack in the same cycle: rx_valid stays 1 and no overrun is flagged.
REQ-030 Shift and sample in the same cycle are both applied independently.
REQ-031 Holding-buffer write and a shift-register load in the same cycle: the load takes the old buffer content if the buffer is full; if the buffer is empty, the load takes all-ones (underrun) and the buffer keeps the new word.
REQ-032 Frame end mid-word: the partial rx word is discarded, rx_valid is not asserted, counters are cleared, and the holding buffer is retained.
REQ-033 Counters are $clog2(DATA_W) bits wide and never exceed DATA_W-1.

Reset
REQ-034 On reset: miso=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0, cs_q=1, all shift registers and counters=0, skip=0.
REQ-035 Reset asserted mid-frame aborts the frame immediately; no pulses are acted on until reset deasserts and a new frame start occurs.
REQ-036 rx_overrun and tx_underrun are cleared only by reset.

Configuration
REQ-037 Macro SPI_LSB_FIRST_EN defined: LSB-first operation; miso is the register LSB, shifts go right, and mosi enters the MSB end.
REQ-038 Macro SPI_LSB_FIRST_EN undefined: MSB-first operation as in REQ-021/023/026.

Verification
REQ-039 tx buffer=8'hA5, cpha=0, frame of 8 sample/shift pairs with mosi=8'h3C pattern -> miso bit sequence 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid=1 on the 8th-sample edge.
REQ-040 cpha=1, tx=8'h81 -> first shift ignored; miso sequence 1,0,0,0,0,0,0,1.
REQ-041 Two consecutive words, no rx_ack -> rx_data=second word, rx_overrun=1; tx buffer empty at second load -> miso all ones, tx_underrun=1.
REQ-042 cs rises after 3 samples, then a new frame -> no rx_valid; new word received correctly from bit 0.
REQ-043 Reset pulsed after 5 samples -> all outputs at REQ-034 values within the same cycle.
REQ-044 With SPI_LSB_FIRST_EN, tx=8'h01 -> miso sequence 1,0,0,0,0,0,0,0.
